// File: rtl/cond_pkg.sv
// Shared types for the branch-condition unit: branch kinds, ARM condition codes, NZCV bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cond_pkg;

  // Branch kinds carried on br_kind
  typedef enum logic [1:0] {
    BR_B    = 2'b00,
    BR_COND = 2'b01,
    BR_CBZ  = 2'b10,
    BR_CBNZ = 2'b11
  } br_kind_t;

  // ARM condition field values
  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_code_t;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int unsigned N_IDX = 3;
  localparam int unsigned Z_IDX = 2;
  localparam int unsigned C_IDX = 1;
  localparam int unsigned V_IDX = 0;

endpackage

// File: rtl/cond_eval.sv
// Evaluates an ARM condition code against an NZCV flag vector.
// Latency: purely combinational.
// Backpressure: none; no handshake.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] nzcv,
  input  logic [3:0] cond_code,
  output logic       cond_true
);

  logic n_f, z_f, c_f, v_f;

  assign n_f = nzcv[N_IDX];
  assign z_f = nzcv[Z_IDX];
  assign c_f = nzcv[C_IDX];
  assign v_f = nzcv[V_IDX];

  // Condition truth table; AL and NV both mean "always"
  always_comb begin
    cond_true = 1'b0;
    case (cond_code_t'(cond_code))
      EQ:      cond_true = z_f;
      NE:      cond_true = !z_f;
      CS:      cond_true = c_f;
      CC:      cond_true = !c_f;
      MI:      cond_true = n_f;
      PL:      cond_true = !n_f;
      VS:      cond_true = v_f;
      VC:      cond_true = !v_f;
      HI:      cond_true = c_f && !z_f;
      LS:      cond_true = !c_f || z_f;
      GE:      cond_true = (n_f == v_f);
      LT:      cond_true = (n_f != v_f);
      GT:      cond_true = !z_f && (n_f == v_f);
      LE:      cond_true = z_f || (n_f != v_f);
      AL:      cond_true = 1'b1;
      NV:      cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Holds architectural NZCV flags and resolves branch decisions (B, B.cond, CBZ, CBNZ).
// Latency: decision appears one cycle after request acceptance; flags update one edge after set_flags.
// Backpressure: one-deep response buffer; req_ready = !resp_valid || resp_ready, decision held until consumed.
// Optional macro COND_FLAG_FWD_EN: a B.cond accepted alongside set_flags sees the incoming ALU flags.
module cond_flag_unit
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  input  logic       alu_carry_out,
  input  logic       set_flags,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] br_kind,
  input  logic [3:0] cond_code,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       take_branch,
  output logic [3:0] nzcv
);

  logic [3:0] nzcv_q, nzcv_d;
  logic       resp_valid_q, resp_valid_d;
  logic       take_branch_q, take_branch_d;

  logic [3:0] alu_flags;
  logic [3:0] eval_flags;
  logic       cond_true;
  logic       accept;
  logic       decision;

  assign alu_flags = {alu_negative, alu_zero, alu_carry_out, alu_overflow};

  // Flags seen by B.cond: optionally bypass the register when flags are being written this cycle
`ifdef COND_FLAG_FWD_EN
  assign eval_flags = set_flags ? alu_flags : nzcv_q;
`else
  assign eval_flags = nzcv_q;
`endif

  cond_eval u_cond_eval (
    .nzcv      (eval_flags),
    .cond_code (cond_code),
    .cond_true (cond_true)
  );

  assign req_ready = !resp_valid_q || resp_ready;
  assign accept    = req_valid && req_ready;

  // Branch decision for the request currently offered
  always_comb begin
    decision = 1'b0;
    case (br_kind_t'(br_kind))
      BR_B:    decision = 1'b1;
      BR_COND: decision = cond_true;
      BR_CBZ:  decision = alu_zero;
      BR_CBNZ: decision = !alu_zero;
      default: decision = 1'b0;
    endcase
  end

  // Next-state: flags follow set_flags only; response slot loads on accept, drains on consume
  always_comb begin
    nzcv_d        = nzcv_q;
    resp_valid_d  = resp_valid_q;
    take_branch_d = take_branch_q;
    if (set_flags) begin
      nzcv_d = alu_flags;
    end
    if (accept) begin
      resp_valid_d  = 1'b1;
      take_branch_d = decision;
    end else if (resp_ready) begin
      resp_valid_d  = 1'b0;
    end
  end

  // State registers; reset wins over any flag write or acceptance in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv_q        <= 4'b0000;
      resp_valid_q  <= 1'b0;
      take_branch_q <= 1'b0;
    end else begin
      nzcv_q        <= nzcv_d;
      resp_valid_q  <= resp_valid_d;
      take_branch_q <= take_branch_d;
    end
  end

  assign nzcv        = nzcv_q;
  assign resp_valid  = resp_valid_q;
  assign take_branch = take_branch_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: flags, condition decode, handshake, forwarding, reset.
// Latency: n/a.
// Backpressure: exercised via resp_ready stalls.
module tb_cond_flag_unit;

  logic       clk;
  logic       reset;
  logic       alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic       set_flags;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] br_kind;
  logic [3:0] cond_code;
  logic       resp_valid;
  logic       resp_ready;
  logic       take_branch;
  logic [3:0] nzcv;

  int n_checks = 0;
  int n_errors = 0;

  cond_flag_unit dut (
    .clk           (clk),
    .reset         (reset),
    .alu_negative  (alu_negative),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .alu_carry_out (alu_carry_out),
    .set_flags     (set_flags),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .br_kind       (br_kind),
    .cond_code     (cond_code),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .take_branch   (take_branch),
    .nzcv          (nzcv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit so checks and drives sit away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_alu(input logic n, input logic z, input logic c, input logic v);
    alu_negative  = n;
    alu_zero      = z;
    alu_carry_out = c;
    alu_overflow  = v;
  endtask

  logic fwd_exp;

  initial begin
`ifdef COND_FLAG_FWD_EN
    fwd_exp = 1'b1;
`else
    fwd_exp = 1'b0;
`endif
    reset      = 1'b1;
    set_flags  = 1'b0;
    req_valid  = 1'b0;
    br_kind    = 2'b00;
    cond_code  = 4'b0000;
    resp_ready = 1'b1;
    set_alu(0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_nzcv", nzcv, 4'h0);
    chk("rst_resp_valid", {3'b0, resp_valid}, 4'h0);
    chk("rst_take", {3'b0, take_branch}, 4'h0);
    chk("rst_req_ready", {3'b0, req_ready}, 4'h1);

    // Flag write N0 Z1 C1 V0 -> 0110, then reset clears it
    set_alu(0, 1, 1, 0);
    set_flags = 1'b1;
    step();
    set_flags = 1'b0;
    chk("flags_0110", nzcv, 4'h6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("flags_after_reset", nzcv, 4'h0);

    // nzcv = 1001 (N=1, V=1)
    set_alu(1, 0, 0, 1);
    set_flags = 1'b1;
    step();
    set_flags = 1'b0;
    set_alu(0, 0, 0, 0);
    chk("flags_1001", nzcv, 4'h9);

    // B.cond GE (N==V) -> 1, back-to-back GT -> 1, EQ -> 0, LT -> 0
    req_valid = 1'b1;
    br_kind   = 2'b01;
    cond_code = 4'b1010;
    step();
    chk("ge_valid", {3'b0, resp_valid}, 4'h1);
    chk("ge_take", {3'b0, take_branch}, 4'h1);
    cond_code = 4'b1100;
    step();
    chk("gt_valid", {3'b0, resp_valid}, 4'h1);
    chk("gt_take", {3'b0, take_branch}, 4'h1);
    cond_code = 4'b0000;
    step();
    chk("eq_take", {3'b0, take_branch}, 4'h0);
    cond_code = 4'b0100;
    step();
    chk("mi_take", {3'b0, take_branch}, 4'h1);
    cond_code = 4'b1011;
    step();
    chk("lt_take", {3'b0, take_branch}, 4'h0);
    req_valid = 1'b0;
    step();
    chk("drain_valid", {3'b0, resp_valid}, 4'h0);

    // CBZ / CBNZ with alu_zero=1; flags must not move
    alu_zero  = 1'b1;
    req_valid = 1'b1;
    br_kind   = 2'b10;
    step();
    chk("cbz_take", {3'b0, take_branch}, 4'h1);
    br_kind = 2'b11;
    step();
    chk("cbnz_take", {3'b0, take_branch}, 4'h0);
    req_valid = 1'b0;
    alu_zero  = 1'b0;
    step();
    chk("cb_nzcv", nzcv, 4'h9);
    chk("cb_drain", {3'b0, resp_valid}, 4'h0);

    // Unconditional B with zero alu flags
    req_valid = 1'b1;
    br_kind   = 2'b00;
    step();
    chk("b_take", {3'b0, take_branch}, 4'h1);
    req_valid = 1'b0;
    step();

    // Backpressure: decision 1 (MI) held for 3 cycles while a PL request (would be 0) waits
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    br_kind    = 2'b01;
    cond_code  = 4'b0100;
    step();
    cond_code = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req_ready", {3'b0, req_ready}, 4'h0);
      chk("stall_valid", {3'b0, resp_valid}, 4'h1);
      chk("stall_take", {3'b0, take_branch}, 4'h1);
      step();
    end
    resp_ready = 1'b1;
    #1;
    chk("release_req_ready", {3'b0, req_ready}, 4'h1);
    step();
    chk("b2b_valid", {3'b0, resp_valid}, 4'h1);
    chk("b2b_take", {3'b0, take_branch}, 4'h0);
    req_valid = 1'b0;
    step();
    chk("b2b_drain", {3'b0, resp_valid}, 4'h0);

    // Same-cycle set_flags (Z=1) with B.cond EQ from nzcv=0
    set_alu(0, 0, 0, 0);
    set_flags = 1'b1;
    step();
    chk("zero_flags", nzcv, 4'h0);
    set_alu(0, 1, 0, 0);
    req_valid = 1'b1;
    br_kind   = 2'b01;
    cond_code = 4'b0000;
    step();
    set_flags = 1'b0;
    req_valid = 1'b0;
    set_alu(0, 0, 0, 0);
    chk("fwd_take", {3'b0, take_branch}, {3'b0, fwd_exp});
    chk("fwd_nzcv", nzcv, 4'h4);
    step();

    // Reset while a response is held; reset also beats set_flags and a new request
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    br_kind    = 2'b00;
    step();
    chk("held_valid", {3'b0, resp_valid}, 4'h1);
    reset     = 1'b1;
    set_flags = 1'b1;
    set_alu(1, 1, 1, 1);
    step();
    reset     = 1'b0;
    set_flags = 1'b0;
    req_valid = 1'b0;
    set_alu(0, 0, 0, 0);
    chk("rst_mid_valid", {3'b0, resp_valid}, 4'h0);
    chk("rst_mid_nzcv", nzcv, 4'h0);
    chk("rst_mid_take", {3'b0, take_branch}, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_resp", {3'b0, resp_valid}, 4'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
